add_div_mix_4_bit: RTL and testbench

ADD_DIV_MIX_4_BIT -- requirements
Module: add_div_mix_4_bit

---
 rtl/add_div_mix_4_bit.sv | 108 ++++++++++
 tb/tb_add_div_mix_4_bit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/add_div_mix_4_bit.sv
// Restoring divider: quotient = product / ((c + d) mod 2^W), one quotient bit per cycle.
// A valid/ready handshake on each side, with a direct path to DONE for a zero divisor.
module add_div_mix_4_bit #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] product,
    input  logic [W-1:0]   c,
    input  logic [W-1:0]   d,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] quotient,
    output logic [W-1:0]   remainder,
    output logic           div_by_zero
);
    localparam int DW = 2 * W;
    localparam int CW = $clog2(DW) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [W-1:0]    s_r;
    logic [DW-1:0]   dvd;
    logic [W:0]      rem;
    logic [CW-1:0]   cnt;

    logic [W-1:0]    s_in;
    logic [W:0]      pr;
    logic            q_bit;
    logic [W:0]      rem_nxt;
    logic [DW-1:0]   dvd_nxt;
    logic            last_step;

    // Divisor sum wraps, carry discarded.
    assign s_in = c + d;

    // The dividend register shifts its MSB into the partial remainder and
    // collects quotient bits at its LSB, so it holds the quotient after DW steps.
    assign pr        = (rem << 1) | {{W{1'b0}}, dvd[DW-1]};
    assign q_bit     = (pr >= {1'b0, s_r});
    assign rem_nxt   = q_bit ? (pr - {1'b0, s_r}) : pr;
    assign dvd_nxt   = {dvd[DW-2:0], q_bit};
    assign last_step = (cnt == CW'(DW - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            s_r         <= '0;
            dvd         <= '0;
            rem         <= '0;
            cnt         <= '0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        s_r      <= s_in;
                        dvd      <= product;
                        rem      <= '0;
                        cnt      <= '0;
                        if (s_in == '0) begin
                            state       <= DONE;
                            out_valid   <= 1'b1;
                            quotient    <= '1;
                            remainder   <= '0;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem <= rem_nxt;
                    dvd <= dvd_nxt;
                    cnt <= cnt + 1'b1;
                    if (last_step) begin
                        state       <= DONE;
                        out_valid   <= 1'b1;
                        quotient    <= dvd_nxt;
                        remainder   <= rem_nxt[W-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_add_div_mix_4_bit.sv
// Bench for add_div_mix_4_bit: directed cases, mid-operation reset, and a
// random valid/ready regression scored against plain integer division.
module tb_add_div_mix_4_bit;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [2*W-1:0] product = '0;
    logic [W-1:0]   c = '0;
    logic [W-1:0]   d = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] quotient;
    logic [W-1:0]   remainder;
    logic           div_by_zero;

    int tests = 0;
    int fails = 0;

    int exp_q_q[$];
    int exp_r_q[$];
    int exp_z_q[$];

    add_div_mix_4_bit #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .product(product), .c(c), .d(d), .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division by the wrapped sum.
    task automatic ref_div(input int p, input int cc, input int dd,
                           output int q, output int r, output int z);
        int s;
        s = (cc + dd) % (1 << W);
        if (s == 0) begin
            q = (1 << (2 * W)) - 1; r = 0; z = 1;
        end else begin
            q = p / s; r = p % s; z = 0;
        end
    endtask

    // One full transaction: accept, wait for result, stall, handshake.
    task automatic run_txn(input string tag, input int p, input int cc, input int dd,
                           input int stall);
        int q, r, z, n, edges;
        ref_div(p, cc, dd, q, r, z);
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        chk({tag, "_ready"}, in_ready, 1);
        product = 8'(p); c = 4'(cc); d = 4'(dd); in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // inputs are don't-care once accepted
        product = 8'($urandom); c = 4'($urandom); d = 4'($urandom);
        // edges counted after the acceptance edge until out_valid is seen
        edges = 0;
        @(negedge clk);
        while (!out_valid && edges < 40) begin @(negedge clk); edges++; end
        chk({tag, "_latency"}, edges, (z != 0) ? 0 : 2 * W);
        chk({tag, "_q"}, quotient, q);
        chk({tag, "_r"}, remainder, r);
        chk({tag, "_dbz"}, div_by_zero, z);
        chk({tag, "_ready_low"}, in_ready, 0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({tag, "_hold_v"}, out_valid, 1);
            chk({tag, "_hold_q"}, quotient, q);
            chk({tag, "_hold_r"}, remainder, r);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_idle_v"}, out_valid, 0);
        chk({tag, "_idle_rdy"}, in_ready, 1);
    endtask

    initial begin
        int n, q, r, z, pushed, popped;
        bit seen;

        // reset state
        #12;
        chk("rst_ready", in_ready, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", in_ready, 1);

        run_txn("t63", 63, 3, 4, 0);
        run_txn("t200", 200, 9, 9, 0);
        run_txn("tdz", 255, 8, 8, 0);
        run_txn("t250", 250, 15, 0, 5);
        run_txn("tmax", 255, 1, 0, 1);
        run_txn("tsmall", 7, 15, 15, 0);

        // reset in the middle of a calculation
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        product = 8'd100; c = 4'd1; d = 4'd2; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ready", in_ready, 0);
        chk("abort_valid", out_valid, 0);
        chk("abort_q", quotient, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin @(negedge clk); if (out_valid) seen = 1'b1; end
        chk("abort_no_result", seen, 0);
        run_txn("t100", 100, 1, 2, 0);

        // random regression with random valid/ready on both sides
        pushed = 0; popped = 0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            in_valid = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            product = 8'($urandom);
            c = 4'($urandom);
            d = ($urandom_range(0, 7) == 0) ? 4'(4'd0 - c) : 4'($urandom);
            if (in_valid && in_ready) begin
                ref_div(int'(product), int'(c), int'(d), q, r, z);
                exp_q_q.push_back(q); exp_r_q.push_back(r); exp_z_q.push_back(z);
                pushed++;
            end
            if (out_valid && out_ready) begin
                chk("rnd_expected", exp_q_q.size() > 0, 1);
                if (exp_q_q.size() > 0) begin
                    chk("rnd_q", quotient, exp_q_q.pop_front());
                    chk("rnd_r", remainder, exp_r_q.pop_front());
                    chk("rnd_dbz", div_by_zero, exp_z_q.pop_front());
                    popped++;
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (exp_q_q.size() > 0 && n < 40) begin
            if (out_valid) begin
                chk("drain_q", quotient, exp_q_q.pop_front());
                chk("drain_r", remainder, exp_r_q.pop_front());
                chk("drain_dbz", div_by_zero, exp_z_q.pop_front());
                popped++;
            end
            @(negedge clk);
            n++;
        end
        chk("rnd_balance", popped, pushed);
        chk("rnd_min_count", pushed > 500, 1);
        out_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
